// File: rtl/cic_comp_fir_pkg.sv
// Shared widths, FSM encoding and droop-compensation coefficients for the CIC compensation FIR.
package cic_comp_fir_pkg;

  localparam int unsigned IN_W_DEF  = 19;
  localparam int unsigned CW_DEF    = 16;
  localparam int unsigned NTAPS_DEF = 16;
  localparam int unsigned ACC_W_DEF = 40;
  localparam int unsigned OUT_W_DEF = 24;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMac   = 2'd1,
    StRound = 2'd2
  } state_e;

  // First half of a symmetric 16-tap set; taps sum to 4096 for unity DC gain at SHIFT=12.
  function automatic logic signed [15:0] coef_half(input logic [2:0] idx);
    case (idx)
      3'd0:    return -16'sd8;
      3'd1:    return -16'sd24;
      3'd2:    return 16'sd16;
      3'd3:    return 16'sd72;
      3'd4:    return -16'sd60;
      3'd5:    return -16'sd184;
      3'd6:    return 16'sd236;
      default: return 16'sd2000;
    endcase
  endfunction

endpackage

// File: rtl/cic_comp_coef_rom.sv
// Combinational coefficient table; only half is stored, the rest is mirrored (h[k] = h[NTAPS-1-k]).
module cic_comp_coef_rom
  import cic_comp_fir_pkg::*;
#(
  parameter int unsigned NTAPS = NTAPS_DEF,
  parameter int unsigned CW    = CW_DEF,
  localparam int unsigned AW   = $clog2(NTAPS)
) (
  input  logic [AW-1:0]        tap_i,
  output logic signed [CW-1:0] coef_o
);

  logic [AW-1:0] half_idx;

  always_comb begin
    half_idx = (tap_i >= AW'(NTAPS / 2)) ? AW'(NTAPS - 1) - tap_i : tap_i;
    coef_o   = CW'(coef_half(3'(half_idx)));
  end

endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR: one time-multiplexed MAC over a circular delay line,
// optional 2x decimation, rounded and saturated signed output.
module cic_comp_fir
  import cic_comp_fir_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned CW    = CW_DEF,
  parameter int unsigned NTAPS = NTAPS_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned SHIFT = 12,
  parameter int unsigned DEC   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned AW = $clog2(NTAPS);
  localparam int unsigned SW = IN_W + 1;
  localparam int unsigned PW = IN_W + 1 + CW;

  localparam logic signed [ACC_W-1:0] Half   = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] MaxOut = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MinOut = ~MaxOut;

  state_e                   state_q, state_d;
  logic signed [SW-1:0]     line_q [NTAPS];
  logic signed [SW-1:0]     line_d [NTAPS];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            tap_q, tap_d;
  logic                     phase_q, phase_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     overrun_q, overrun_d;

  logic signed [SW-1:0]     in_sx;
  logic                     phase_nxt;
  logic [AW-1:0]            rd_idx;
  logic signed [SW-1:0]     sample;
  logic signed [CW-1:0]     coef;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  rnd_sum;
  logic signed [ACC_W-1:0]  shifted;

  cic_comp_coef_rom #(
    .NTAPS (NTAPS),
    .CW    (CW)
  ) u_coef_rom (
    .tap_i  (tap_q),
    .coef_o (coef)
  );

  always_comb begin
    in_sx   = {1'b0, in_data};
    // wr_ptr_q already points past the newest sample for the whole MAC sequence.
    rd_idx  = wr_ptr_q - AW'(1) - tap_q;
    sample  = line_q[rd_idx];
    prod    = PW'(sample) * PW'(coef);
    rnd_sum = acc_q + Half;
    shifted = rnd_sum >>> SHIFT;
  end

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    wr_ptr_d    = wr_ptr_q;
    tap_d       = tap_q;
    phase_d     = phase_q;
    phase_nxt   = phase_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          line_d[wr_ptr_q] = in_sx;
          wr_ptr_d         = wr_ptr_q + AW'(1);
          phase_nxt        = (DEC == 2) ? ~phase_q : 1'b0;
          phase_d          = phase_nxt;
          if (!phase_nxt) begin
            state_d = StMac;
            acc_d   = '0;
            tap_d   = '0;
          end
        end
      end
      StMac: begin
        acc_d = acc_q + ACC_W'(prod);
        tap_d = tap_q + AW'(1);
        if (tap_q == AW'(NTAPS - 1)) begin
          state_d = StRound;
        end
      end
      StRound: begin
        out_valid_d = 1'b1;
        if (shifted > MaxOut) begin
          out_data_d = MaxOut[OUT_W-1:0];
        end else if (shifted < MinOut) begin
          out_data_d = MinOut[OUT_W-1:0];
        end else begin
          out_data_d = shifted[OUT_W-1:0];
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (in_valid && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      for (int i = 0; i < NTAPS; i++) begin
        line_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      tap_q       <= '0;
      phase_q     <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      wr_ptr_q    <= wr_ptr_d;
      tap_q       <= tap_d;
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != StIdle);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench: three instances (DEC=1, DEC=2, SHIFT=1) sharing clock, reset and input stream.
module tb_cic_comp_fir;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [18:0]      in_data = '0;
  logic [2:0]       ov;
  logic [2:0][23:0] od;
  logic [2:0]       bsy;
  logic [2:0]       ovr;

  int checks = 0;
  int errors = 0;

  // Hand-written expected coefficients (symmetric, sum 4096).
  int h [16] = '{-8, -24, 16, 72, -60, -184, 236, 2000,
                 2000, 236, -184, -60, 72, 16, -24, -8};

  always #5 clk = ~clk;

  cic_comp_fir #(.DEC(1), .SHIFT(12)) u_dut0 (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_data (in_data),
    .out_valid (ov[0]), .out_data (od[0]), .busy (bsy[0]), .overrun (ovr[0])
  );

  cic_comp_fir #(.DEC(2), .SHIFT(12)) u_dut1 (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_data (in_data),
    .out_valid (ov[1]), .out_data (od[1]), .busy (bsy[1]), .overrun (ovr[1])
  );

  cic_comp_fir #(.DEC(1), .SHIFT(1)) u_dut2 (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_data (in_data),
    .out_valid (ov[2]), .out_data (od[2]), .busy (bsy[2]), .overrun (ovr[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle strobe; returns at the negedge of the cycle after the accepting edge.
  task automatic pulse(input logic [18:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Watches one instance up to 20 cycles after the strobe; i counts cycles since the strobe.
  task automatic watch(input int sel, input bit exp_v, input bit chk_val,
                       input logic [23:0] exp, input int first_i, input string tag);
    int          cnt = 0;
    int          lat = 0;
    logic [23:0] val = '0;
    for (int i = first_i; i <= 20; i++) begin
      if (ov[sel]) begin
        if (cnt == 0) begin
          lat = i;
          val = od[sel];
        end
        cnt++;
      end
      @(negedge clk);
    end
    check({tag, "_count"}, cnt, exp_v ? 32'd1 : 32'd0);
    if (exp_v) begin
      check({tag, "_latency"}, lat, 32'd18);
      if (chk_val) check({tag, "_value"}, {8'd0, val}, {8'd0, exp});
    end
  endtask

  task automatic impulse_run(input string tag);
    pulse(19'd4096);
    watch(0, 1'b1, 1'b1, 24'(h[0]), 1, tag);
    for (int k = 1; k < 16; k++) begin
      pulse(19'd0);
      watch(0, 1'b1, 1'b1, 24'(h[k]), 1, tag);
    end
    pulse(19'd0);
    watch(0, 1'b1, 1'b1, 24'd0, 1, tag);
  endtask

  initial begin
    int cnt6;

    // Reset state
    do_reset();
    check("rst_out_valid", {31'd0, ov[0]}, 32'd0);
    check("rst_out_data", {8'd0, od[0]}, 32'd0);
    check("rst_busy", {31'd0, bsy[0]}, 32'd0);
    check("rst_overrun", {31'd0, ovr[0]}, 32'd0);

    // Impulse response, DEC=1
    impulse_run("impulse");

    // DC gain and latency, DEC=1
    do_reset();
    for (int i = 0; i < 32; i++) begin
      pulse(19'd1000);
      watch(0, 1'b1, i >= 16, 24'd1000, 1, "dc");
    end

    // DEC=2: outputs only after even-numbered samples; tiny ramp rounds to 0
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      pulse(19'(i));
      watch(1, (i % 2) == 0, 1'b1, 24'd0, 1, "dec2");
    end

    // Overrun: second strobe 5 cycles after the first is dropped
    do_reset();
    check("ovr_before", {31'd0, ovr[0]}, 32'd0);
    pulse(19'd4096);
    repeat (3) @(negedge clk);
    pulse(19'd777);
    watch(0, 1'b1, 1'b1, 24'(h[0]), 6, "ovr_first");
    check("ovr_set", {31'd0, ovr[0]}, 32'd1);
    pulse(19'd0);
    watch(0, 1'b1, 1'b1, 24'(h[1]), 1, "ovr_line");
    check("ovr_sticky", {31'd0, ovr[0]}, 32'd1);

    // Saturation with SHIFT=1
    do_reset();
    for (int i = 0; i < 15; i++) begin
      pulse(19'h7FFFF);
      repeat (19) @(negedge clk);
    end
    pulse(19'h7FFFF);
    watch(2, 1'b1, 1'b1, 24'h7FFFFF, 1, "sat");

    // Reset asserted in MAC cycle 7
    do_reset();
    pulse(19'd4096);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, bsy[0]}, 32'd0);
    check("midrst_overrun", {31'd0, ovr[0]}, 32'd0);
    cnt6 = 0;
    for (int i = 0; i < 15; i++) begin
      if (ov[0]) cnt6++;
      @(negedge clk);
    end
    check("midrst_no_output", cnt6, 32'd0);
    impulse_run("impulse_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
